// File: rtl/rpsc_pkg.sv
// Shared types for the RF-on permit sequencer: state and fault encodings,
// per-state permit masks and the abort-cause helper.
package rpsc_pkg;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_G2_PERM = 3'd1,
      S_G2_ON   = 3'd2,
      S_DR_PERM = 3'd3,
      S_DR_ON   = 3'd4,
      S_RF_RED  = 3'd5,
      S_RF_FULL = 3'd6,
      S_FAULT   = 3'd7
   } seq_state_t;

   typedef enum logic [3:0] {
      FC_NONE    = 4'd0,
      FC_INTLK   = 4'd1,
      FC_G2_TO   = 4'd2,
      FC_DR_TO   = 4'd3,
      FC_G2_LOSS = 4'd4,
      FC_DR_LOSS = 4'd5
   } fault_code_t;

   // {g2_perm, g2_on, dr_perm, dr_on, rf_red, rf_full}
   localparam logic [5:0] PM_NONE    = 6'b000000;
   localparam logic [5:0] PM_G2_PERM = 6'b100000;
   localparam logic [5:0] PM_G2_ON   = 6'b110000;
   localparam logic [5:0] PM_DR_PERM = 6'b111000;
   localparam logic [5:0] PM_DR_ON   = 6'b111100;
   localparam logic [5:0] PM_RF_RED  = 6'b111110;
   localparam logic [5:0] PM_RF_FULL = 6'b111111;

   function automatic logic [5:0] perm_mask(seq_state_t s);
      logic [5:0] m;
      m = PM_NONE;
      unique case (s)
         S_G2_PERM: m = PM_G2_PERM;
         S_G2_ON:   m = PM_G2_ON;
         S_DR_PERM: m = PM_DR_PERM;
         S_DR_ON:   m = PM_DR_ON;
         S_RF_RED:  m = PM_RF_RED;
         S_RF_FULL: m = PM_RF_FULL;
         default:   m = PM_NONE;
      endcase
      return m;
   endfunction

   function automatic fault_code_t abort_cause(
      seq_state_t s,
      logic       ilk,
      logic       g2,
      logic       dr
   );
      fault_code_t c;
      c = FC_NONE;
      if (s != S_IDLE && s != S_FAULT) begin
         if (!ilk)
            c = FC_INTLK;
         else if (!g2 && s inside {S_DR_PERM, S_DR_ON,
                                   S_RF_RED, S_RF_FULL})
            c = FC_G2_LOSS;
         else if (!dr && s inside {S_RF_RED, S_RF_FULL})
            c = FC_DR_LOSS;
      end
      return c;
   endfunction

endpackage

// File: rtl/rpsc_ms_timer.sv
// Millisecond prescaler plus saturating ms counter with synchronous clear;
// also exposes the count that the next clock edge will load.
module rpsc_ms_timer
#(
   parameter int unsigned CLK_PER_MS = 50000,
   parameter int unsigned MS_W       = 16
)
(
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            clr_i,
   output logic [MS_W-1:0] ms_cnt_o,
   output logic [MS_W-1:0] ms_nxt_o
);

   localparam int unsigned PW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
   localparam logic [PW-1:0] PRE_TOP = PW'(CLK_PER_MS - 1);

   logic [PW-1:0]   pre_q, pre_d;
   logic [MS_W-1:0] cnt_q, cnt_d;
   logic            tick;

   assign tick = (pre_q == PRE_TOP);

   always_comb begin
      pre_d = tick ? '0 : pre_q + 1'b1;
      cnt_d = (tick && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pre_q <= '0;
         cnt_q <= '0;
      end else if (clr_i) begin
         pre_q <= '0;
         cnt_q <= '0;
      end else begin
         pre_q <= pre_d;
         cnt_q <= cnt_d;
      end
   end

   assign ms_cnt_o = cnt_q;
   assign ms_nxt_o = cnt_d;

endmodule

// File: rtl/rpsc_rf_permit_seq.sv
// RF-on permit sequencer driving the card-11 permit inputs.
// Define RPSC_FAULT_CODE_EN to add the latched fault_code output.
module rpsc_rf_permit_seq
   import rpsc_pkg::*;
#(
   parameter int unsigned CLK_PER_MS    = 50000,
   parameter int unsigned DWELL_MS      = 10,
   parameter int unsigned CA_DELAY_MS   = 100,
   parameter int unsigned FB_TIMEOUT_MS = 200,
   parameter int unsigned REDUCED_MS    = 500,
   parameter int unsigned MS_W          = 16
)
(
   input  logic       clk,
   input  logic       reset,
   input  logic       reset_hold_error,
   input  logic       on_req,
   input  logic       full_req,
   input  logic       interlock_ok,
   input  logic       g2_fb,
   input  logic       dr_fb,
   output logic       g2_on_perm,
   output logic       g2_on,
   output logic       dr_amp_on_perm,
   output logic       dr_amp_on,
   output logic       rf_reduced_permitted,
   output logic       rf_permitted,
   output logic       ca_delay,
   output logic       fault,
   output logic [2:0] seq_state
`ifdef RPSC_FAULT_CODE_EN
   ,
   output logic [3:0] fault_code
`endif
);

   localparam logic [MS_W-1:0] DWELL_C = MS_W'(DWELL_MS);
   localparam logic [MS_W-1:0] CA_C    = MS_W'(CA_DELAY_MS);
   localparam logic [MS_W-1:0] FBTO_C  = MS_W'(FB_TIMEOUT_MS);
   localparam logic [MS_W-1:0] RED_C   = MS_W'(REDUCED_MS);

   seq_state_t      state_q, state_d;
   fault_code_t     cause;
   logic [MS_W-1:0] ms_cnt, ms_nxt;
   logic            tmr_clr;
   logic            active;

   assign tmr_clr = (state_d != state_q);

   rpsc_ms_timer #(
      .CLK_PER_MS (CLK_PER_MS),
      .MS_W       (MS_W)
   ) u_timer (
      .clk_i    (clk),
      .rst_ni   (reset),
      .clr_i    (tmr_clr),
      .ms_cnt_o (ms_cnt),
      .ms_nxt_o (ms_nxt)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         state_q <= S_IDLE;
      else
         state_q <= state_d;
   end

   // Steps test the count about to load, so an N ms dwell ends exactly
   // N*CLK_PER_MS cycles after entry.
   always_comb begin
      state_d = state_q;
      cause   = abort_cause(state_q, interlock_ok, g2_fb, dr_fb);
      active  = (state_q != S_IDLE) && (state_q != S_FAULT);
      if (cause != FC_NONE) begin
         state_d = S_FAULT;
      end else if (active && !on_req) begin
         state_d = S_IDLE;
      end else begin
         unique case (state_q)
            S_IDLE:
               if (on_req && interlock_ok) state_d = S_G2_PERM;
            S_G2_PERM:
               if (ms_nxt == DWELL_C) state_d = S_G2_ON;
            S_G2_ON:
               if (g2_fb && ms_nxt >= CA_C)
                  state_d = S_DR_PERM;
               else if (!g2_fb && ms_nxt >= FBTO_C)
                  state_d = S_FAULT;
            S_DR_PERM:
               if (ms_nxt == DWELL_C) state_d = S_DR_ON;
            S_DR_ON:
               if (dr_fb)
                  state_d = S_RF_RED;
               else if (ms_nxt >= FBTO_C)
                  state_d = S_FAULT;
            S_RF_RED:
               if (full_req && ms_nxt >= RED_C) state_d = S_RF_FULL;
            S_RF_FULL:
               if (!full_req) state_d = S_RF_RED;
            S_FAULT:
               if (reset_hold_error && !on_req) state_d = S_IDLE;
            default:
               state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      {g2_on_perm, g2_on, dr_amp_on_perm,
       dr_amp_on, rf_reduced_permitted, rf_permitted} = perm_mask(state_q);
      ca_delay  = (state_q == S_G2_ON) && (ms_cnt < CA_C);
      fault     = (state_q == S_FAULT);
      seq_state = state_q;
   end

`ifdef RPSC_FAULT_CODE_EN
   fault_code_t fc_q, fc_d;

   always_comb begin
      fc_d = fc_q;
      if (state_d == S_FAULT && state_q != S_FAULT) begin
         if (cause != FC_NONE)
            fc_d = cause;
         else if (state_q == S_G2_ON)
            fc_d = FC_G2_TO;
         else
            fc_d = FC_DR_TO;
      end else if (state_d != S_FAULT) begin
         fc_d = FC_NONE;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         fc_q <= FC_NONE;
      else
         fc_q <= fc_d;
   end

   assign fault_code = fc_q;
`endif

endmodule
